// File: rtl/text_pkg.sv
// Shared constants and types for the character-stream writer of the VGA text screen.
package text_pkg;
    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 60;
    localparam int COL_W    = 7;
    localparam int ROW_W    = 6;

    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] FF    = 8'h0C;
    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic {IDLE, CLEAR} state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction
endpackage

// File: rtl/text_writer.sv
// Turns an ASCII byte stream into one-cycle text-buffer cell writes and tracks the cursor.
// Write latency 1 cycle; char_ready drops during a clear sweep or while clear_req is asserted.
module text_writer
    import text_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic             clk_25,
    input  logic             reset,
    input  logic [7:0]       char_in,
    input  logic             char_valid,
    output logic             char_ready,
    input  logic             clear_req,
    output logic [COL_W-1:0] text_add_col,
    output logic [ROW_W-1:0] text_add_row,
    output logic [7:0]       text_data,
    output logic             wr_en,
    output logic [COL_W-1:0] cursor_col,
    output logic [ROW_W-1:0] cursor_row,
    output logic             busy
);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

    state_t           state, state_n;
    logic [COL_W-1:0] cur_col_n, sw_col, sw_col_n, add_col_n;
    logic [ROW_W-1:0] cur_row_n, sw_row, sw_row_n, add_row_n;
    logic [7:0]       data_n;
    logic             wr_en_n, sw_done, sw_done_n;
    logic             accept;

    assign char_ready = (state == IDLE) && !clear_req;
    assign busy       = (state == CLEAR);
    assign accept     = char_valid && char_ready;

    always_comb begin
        state_n   = state;
        cur_col_n = cursor_col;
        cur_row_n = cursor_row;
        sw_col_n  = sw_col;
        sw_row_n  = sw_row;
        sw_done_n = sw_done;
        wr_en_n   = 1'b0;
        add_col_n = text_add_col;
        add_row_n = text_add_row;
        data_n    = text_data;

        case (state)
            IDLE: begin
                if (clear_req || (accept && char_in == FF)) begin
                    state_n   = CLEAR;
                    cur_col_n = '0;
                    cur_row_n = '0;
                    sw_col_n  = '0;
                    sw_row_n  = '0;
                    sw_done_n = 1'b0;
                end else if (accept) begin
                    if (is_printable(char_in)) begin
                        wr_en_n   = 1'b1;
                        add_col_n = cursor_col;
                        add_row_n = cursor_row;
                        data_n    = char_in;
                        if (cursor_col == COL_MAX) begin
                            cur_col_n = '0;
                            cur_row_n = (cursor_row == ROW_MAX) ? '0 : cursor_row + 1'b1;
                        end else begin
                            cur_col_n = cursor_col + 1'b1;
                        end
                    end else if (char_in == CR) begin
                        cur_col_n = '0;
                    end else if (char_in == LF) begin
                        cur_col_n = '0;
                        cur_row_n = (cursor_row == ROW_MAX) ? '0 : cursor_row + 1'b1;
                    end else if (char_in == BS && cursor_col != '0) begin
                        // Erase the cell the cursor steps back onto.
                        cur_col_n = cursor_col - 1'b1;
                        wr_en_n   = 1'b1;
                        add_col_n = cursor_col - 1'b1;
                        add_row_n = cursor_row;
                        data_n    = SPACE;
                    end
                end
            end
            CLEAR: begin
                cur_col_n = '0;
                cur_row_n = '0;
                if (clear_req) begin
                    sw_col_n  = '0;
                    sw_row_n  = '0;
                    sw_done_n = 1'b0;
                end else if (sw_done) begin
                    // One extra cycle after the last write so busy falls after it.
                    state_n = IDLE;
                end else begin
                    wr_en_n   = 1'b1;
                    add_col_n = sw_col;
                    add_row_n = sw_row;
                    data_n    = SPACE;
                    if (sw_col == COL_MAX) begin
                        sw_col_n = '0;
                        if (sw_row == ROW_MAX) begin
                            sw_row_n  = '0;
                            sw_done_n = 1'b1;
                        end else begin
                            sw_row_n = sw_row + 1'b1;
                        end
                    end else begin
                        sw_col_n = sw_col + 1'b1;
                    end
                end
            end
            default: state_n = CLEAR;
        endcase
    end

    always_ff @(posedge clk_25) begin
        if (reset) begin
            state        <= CLEAR;
            cursor_col   <= '0;
            cursor_row   <= '0;
            sw_col       <= '0;
            sw_row       <= '0;
            sw_done      <= 1'b0;
            wr_en        <= 1'b0;
            text_add_col <= '0;
            text_add_row <= '0;
            text_data    <= SPACE;
        end else begin
            state        <= state_n;
            cursor_col   <= cur_col_n;
            cursor_row   <= cur_row_n;
            sw_col       <= sw_col_n;
            sw_row       <= sw_row_n;
            sw_done      <= sw_done_n;
            wr_en        <= wr_en_n;
            text_add_col <= add_col_n;
            text_add_row <= add_row_n;
            text_data    <= data_n;
        end
    end
endmodule
